// File: rtl/prog_loader_if.sv
// Program-load stream (valid/ready) and program-RAM write port.
// The loader uses the slave modport; the source/RAM side uses the master modport.
interface prog_loader_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// Streams program words into program RAM, then generates the core's step tick.
// All outputs are registered and updated together with the state.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TICK_DIV   = 8
) (
  input  logic                clk,
  input  logic                reset_count,
  input  logic                start_load,
  prog_loader_if.slave        bus,
  input  logic                run_enable,
  output logic                run_tick,
  output logic                loading,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_WIDTH:0] word_count
);

  localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

  state_t           state;
  logic             last_q;
  logic [DIV_W-1:0] div_q;

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state        <= IDLE;
      last_q       <= 1'b0;
      div_q        <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      run_tick     <= 1'b0;
      loading      <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      word_count   <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      run_tick  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_load) begin
            state        <= LOAD;
            bus.in_ready <= 1'b1;
            loading      <= 1'b1;
            bus.wr_addr  <= '0;
            word_count   <= '0;
            overflow     <= 1'b0;
          end
        end

        LOAD: begin
          // in_ready is always high here, so in_valid alone completes the handshake
          if (bus.in_valid) begin
            state        <= WRITE;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b1;
            bus.wr_data  <= DATA_WIDTH'(bus.in_data);
            last_q       <= bus.in_last;
          end
        end

        WRITE: begin
          word_count <= word_count + 1'b1;
          if (start_load) begin
            // restart wins over both the increment and the normal exit
            state        <= LOAD;
            bus.in_ready <= 1'b1;
            bus.wr_addr  <= '0;
            word_count   <= '0;
            overflow     <= 1'b0;
          end else if (last_q || (bus.wr_addr == '1)) begin
            state    <= RUN;
            loading  <= 1'b0;
            done     <= 1'b1;
            div_q    <= '0;
            overflow <= !last_q;
          end else begin
            state        <= LOAD;
            bus.in_ready <= 1'b1;
            bus.wr_addr  <= bus.wr_addr + 1'b1;
          end
        end

        RUN: begin
          if (start_load) begin
            state        <= LOAD;
            bus.in_ready <= 1'b1;
            loading      <= 1'b1;
            done         <= 1'b0;
            div_q        <= '0;
            bus.wr_addr  <= '0;
            word_count   <= '0;
            overflow     <= 1'b0;
          end else if (run_enable) begin
            // tick is issued in the cycle after the divider's last count
            if (div_q == DIV_MAX) begin
              div_q    <= '0;
              run_tick <= 1'b1;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: transaction-level reference model checked every cycle,
// plus literal expectations for the directed scenarios and a randomized phase.
module tb_prog_loader;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned TD    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_count;
  logic          start_load;
  logic          run_enable;
  logic          run_tick;
  logic          loading;
  logic          done;
  logic          overflow;
  logic [AW:0]   word_count;

  prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset_count(reset_count),
    .start_load (start_load),
    .bus        (bus.slave),
    .run_enable (run_enable),
    .run_tick   (run_tick),
    .loading    (loading),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int base     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting for a word, 2 writing, 3 running.
  int          m_phase;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_data;
  bit          m_last, m_ovf, m_tick;
  int          m_count, m_enc;
  bit [DW-1:0] exp_ram [DEPTH];
  bit [DW-1:0] tb_ram  [DEPTH];

  function automatic void model_reset();
    m_phase = 0; m_addr = 0; m_data = 0; m_last = 0; m_ovf = 0;
    m_tick = 0; m_count = 0; m_enc = 0;
  endfunction

  function automatic void begin_load();
    m_phase = 1; m_addr = 0; m_count = 0; m_ovf = 0;
  endfunction

  function automatic void enter_run();
    m_phase = 3; m_enc = 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (bus.wr_en) tb_ram[bus.wr_addr] = bus.wr_data;
    if (reset_count) model_reset();
    else begin
      m_tick = 0;
      case (m_phase)
        0: if (start_load) begin_load();
        1: if (bus.in_valid) begin
             m_data = bus.in_data; m_last = bus.in_last; m_phase = 2;
           end
        2: begin
             exp_ram[m_addr] = m_data;
             m_count++;
             if (start_load) begin_load();
             else if (m_last) enter_run();
             else if (int'(m_addr) == DEPTH - 1) begin m_ovf = 1; enter_run(); end
             else begin m_addr++; m_phase = 1; end
           end
        default: if (start_load) begin_load();
                 else if (run_enable) begin
                   m_enc++;
                   if (m_enc % TD == 0) m_tick = 1;
                 end
      endcase
    end
  end

  typedef struct { int c; int a; int d; } wr_t;
  wr_t wr_log[$];
  int  tick_log[$];

  always @(posedge clk) begin
    #1;
    chk("in_ready",   bus.in_ready, 32'(m_phase == 1));
    chk("wr_en",      bus.wr_en,    32'(m_phase == 2));
    chk("wr_addr",    bus.wr_addr,  32'(m_addr));
    chk("wr_data",    bus.wr_data,  32'(m_data));
    chk("loading",    loading,      32'(m_phase == 1 || m_phase == 2));
    chk("done",       done,         32'(m_phase == 3));
    chk("overflow",   overflow,     32'(m_ovf));
    chk("word_count", word_count,   32'(m_count));
    chk("run_tick",   run_tick,     32'(m_tick));
    chk("wr_tick_excl", 32'(bus.wr_en && run_tick), 32'd0);
    if (bus.wr_en) wr_log.push_back('{cyc, int'(bus.wr_addr), int'(bus.wr_data)});
    if (run_tick)  tick_log.push_back(cyc);
  end

  typedef struct { bit [DW-1:0] d; bit l; int stall; } word_t;
  word_t src_q[$];
  bit    chaos = 0;

  task automatic step();
    @(negedge clk);
    start_load = 1'b0;
    if (chaos) begin
      run_enable = ($urandom_range(0, 3) != 0);
      start_load = ($urandom_range(0, 59) == 0);
    end
  endtask

  task automatic begin_prog();
    step();
    start_load = 1'b1;
    base = cyc;
  endtask

  task automatic stream(input int budget);
    int stall;
    bit finished;
    stall = (src_q.size() > 0) ? src_q[0].stall : 0;
    finished = 0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (src_q.size() == 0 || done) begin
        bus.in_valid = 1'b0;
        finished = 1;
        break;
      end
      if (stall > 0) begin
        bus.in_valid = 1'b0;
        stall--;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = src_q[0].d;
        bus.in_last  = src_q[0].l;
        if (bus.in_ready) begin
          void'(src_q.pop_front());
          stall = (src_q.size() > 0) ? src_q[0].stall : 0;
        end
      end
    end
    checks++;
    if (!finished) begin
      failures++;
      bus.in_valid = 1'b0;
      $display("FAIL stream_timeout: got busy expected finished within %0d cycles", budget);
    end
  endtask

  task automatic wait_rel(input int r);
    for (int k = 0; k < 2000 && cyc < base + r; k++) step();
  endtask

  task automatic check_writes(input string name, input int n, input bit [DW-1:0] d []);
    chk({name, "_nwrites"}, wr_log.size(), n);
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      chk({name, "_addr"}, wr_log[i].a, i);
      chk({name, "_data"}, wr_log[i].d, 32'(d[i]));
    end
  endtask

  initial begin
    bit [DW-1:0] dv [];
    reset_count  = 1'b1;
    start_load   = 1'b0;
    run_enable   = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) begin tb_ram[a] = 0; exp_ram[a] = 0; end
    repeat (3) @(negedge clk);
    reset_count = 1'b0;
    chk("rst_done", done, 0);
    chk("rst_word_count", word_count, 0);

    // three-word program, continuous source
    wr_log.delete(); tick_log.delete();
    src_q = '{'{8'h41, 1'b0, 0}, '{8'h52, 1'b0, 0}, '{8'h83, 1'b1, 0}};
    begin_prog();
    stream(50);
    wait_rel(8);
    dv = new[3];
    dv[0] = 8'h41; dv[1] = 8'h52; dv[2] = 8'h83;
    check_writes("t1", 3, dv);
    for (int i = 0; i < 3 && i < wr_log.size(); i++)
      chk("t1_wr_cycle", wr_log[i].c - base, 2 + 2 * i);
    chk("t1_done", done, 1);
    chk("t1_count", word_count, 3);
    chk("t1_overflow", overflow, 0);

    // tick cadence, then a 3-cycle run_enable gap
    wait_rel(50);
    chk("t1_ticks40", tick_log.size(), 5);
    if (tick_log.size() > 0) chk("t1_first_tick", tick_log[0] - base, 15);
    run_enable = 1'b0;
    wait_rel(53);
    run_enable = 1'b1;
    wait_rel(60);
    chk("t1_ticks_gap", tick_log.size(), 6);
    if (tick_log.size() > 5) chk("t1_delayed_tick", tick_log[5] - base, 58);

    // stalled source: 5 idle cycles before each later word
    wr_log.delete();
    src_q = '{'{8'h10, 1'b0, 0}, '{8'h21, 1'b0, 5}, '{8'h32, 1'b0, 5}, '{8'h43, 1'b1, 5}};
    begin_prog();
    stream(200);
    repeat (3) step();
    dv = new[4];
    dv[0] = 8'h10; dv[1] = 8'h21; dv[2] = 8'h32; dv[3] = 8'h43;
    check_writes("t2", 4, dv);
    for (int i = 1; i < 4 && i < wr_log.size(); i++)
      chk("t2_spacing", wr_log[i].c - wr_log[i-1].c, 6);
    chk("t2_count", word_count, 4);

    // 17 words with no last marker overflow the 16-entry RAM
    wr_log.delete();
    src_q.delete();
    dv = new[17];
    for (int i = 0; i < 17; i++) begin
      dv[i] = DW'($urandom);
      src_q.push_back('{dv[i], 1'b0, 0});
    end
    begin_prog();
    stream(200);
    repeat (4) step();
    check_writes("t3", 16, dv);
    chk("t3_overflow", overflow, 1);
    chk("t3_done", done, 1);
    chk("t3_count", word_count, 16);
    chk("t3_in_ready", bus.in_ready, 0);
    chk("t3_leftover", src_q.size(), 1);
    src_q.delete();

    // reload from RUN clears done/overflow and rewrites from address 0
    wr_log.delete();
    begin_prog();
    step();
    chk("t4_done_clr", done, 0);
    chk("t4_addr0", bus.wr_addr, 0);
    chk("t4_ovf_clr", overflow, 0);
    src_q = '{'{8'hA5, 1'b0, 0}, '{8'h5A, 1'b1, 0}};
    stream(50);
    repeat (3) step();
    dv = new[2];
    dv[0] = 8'hA5; dv[1] = 8'h5A;
    check_writes("t4", 2, dv);
    chk("t4_count", word_count, 2);
    chk("t4_done", done, 1);

    // reset lands on a pending accept: the write must never be issued
    wr_log.delete();
    begin_prog();
    for (int k = 0; k < 20; k++) begin
      step();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      bus.in_last  = 1'b0;
      if (bus.in_ready) break;
    end
    reset_count = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t5_wr_en", bus.wr_en, 0);
    chk("t5_in_ready", bus.in_ready, 0);
    chk("t5_loading", loading, 0);
    chk("t5_done", done, 0);
    chk("t5_count", word_count, 0);
    chk("t5_nwrites", wr_log.size(), 0);
    reset_count = 1'b0;
    src_q = '{'{8'h77, 1'b0, 0}, '{8'h88, 1'b1, 0}};
    begin_prog();
    stream(50);
    repeat (3) step();
    dv = new[2];
    dv[0] = 8'h77; dv[1] = 8'h88;
    check_writes("t5", 2, dv);

    // randomized programs, stalls, run_enable and stray start_load pulses
    chaos = 1;
    for (int it = 0; it < 30; it++) begin
      int len;
      bit marked;
      len = $urandom_range(1, 20);
      marked = ($urandom_range(0, 3) != 0);
      src_q.delete();
      for (int i = 0; i < len; i++)
        src_q.push_back('{DW'($urandom), marked && (i == len - 1), $urandom_range(0, 3)});
      begin_prog();
      stream(400);
      repeat ($urandom_range(5, 40)) step();
    end
    chaos = 0;
    run_enable = 1'b1;
    repeat (2) step();

    for (int a = 0; a < int'(DEPTH); a++)
      chk("ram_contents", tb_ram[a], exp_ram[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
